// File: rtl/cory_dmx2_burst_pkg.sv
// Shared definitions for the burst-locked 2-way demultiplexer.
// FSM state encodings used by the top-level router.
package cory_defs;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

endpackage

// File: rtl/cory_dmx2_burst_skid2.sv
// cory_skid2: 2-entry valid/ready buffer with registered output.
// A push and a pop in the same cycle keep the occupancy unchanged.
module cory_skid2 #(
    parameter int N = 9
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic [N-1:0] push_data,
    output logic         full,
    output logic         valid,
    output logic [N-1:0] data,
    input  logic         ready
);

    logic [N-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         do_push;
    logic         pop;

    assign full    = (count == 2'd2);
    assign valid   = (count != 2'd0);
    assign do_push = push & ~full;
    assign pop     = valid & ready;
    // Empty buffer presents zeros so last/data never show stale or unknown values.
    assign data    = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/cory_dmx2_burst.sv
// Burst-locked 2-way demultiplexer: routes each tagged burst to output 0 or 1,
// locking the route on the header beat and holding it for len+1 beats.
module cory_dmx2_burst
    import cory_defs::*;
#(
    parameter int N = 8,
    parameter int L = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_a_v,
    input  logic [N-1:0] i_a_d,
    input  logic         i_a_s,
    input  logic [L-1:0] i_a_len,
    output logic         o_a_r,
    output logic         o_z0_v,
    output logic [N-1:0] o_z0_d,
    output logic         o_z0_last,
    input  logic         i_z0_r,
    output logic         o_z1_v,
    output logic [N-1:0] o_z1_d,
    output logic         o_z1_last,
    input  logic         i_z1_r,
    output logic         o_busy
);

    localparam logic [L-1:0] ONE = {{(L-1){1'b0}}, 1'b1};

    state_t       state, state_next;
    logic [L-1:0] cnt, cnt_next;
    logic         sel_q, sel_next;
    logic         rsel;
    logic         accept;
    logic         last;
    logic         full0, full1;

    // Only the buffer on the current route can hold off the input.
    assign rsel   = (state == ST_IDLE) ? i_a_s : sel_q;
    assign o_a_r  = rsel ? ~full1 : ~full0;
    assign accept = i_a_v & o_a_r;
    assign o_busy = (state == ST_BURST);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        sel_next   = sel_q;
        last       = 1'b0;
        case (state)
            ST_IDLE: begin
                last = (i_a_len == '0);
                if (accept && (i_a_len != '0)) begin
                    sel_next   = i_a_s;
                    cnt_next   = i_a_len;
                    state_next = ST_BURST;
                end
            end
            ST_BURST: begin
                last = (cnt == ONE);
                if (accept) begin
                    cnt_next = cnt - ONE;
                    if (cnt == ONE) begin
                        state_next = ST_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            sel_q <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            sel_q <= sel_next;
        end
    end

    cory_skid2 #(.N(N + 1)) u_skid0 (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (accept & ~rsel),
        .push_data ({last, i_a_d}),
        .full      (full0),
        .valid     (o_z0_v),
        .data      ({o_z0_last, o_z0_d}),
        .ready     (i_z0_r)
    );

    cory_skid2 #(.N(N + 1)) u_skid1 (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (accept & rsel),
        .push_data ({last, i_a_d}),
        .full      (full1),
        .valid     (o_z1_v),
        .data      ({o_z1_last, o_z1_d}),
        .ready     (i_z1_r)
    );

endmodule

// File: tb/tb_cory_dmx2_burst.sv
// Scoreboard bench for cory_dmx2_burst: driver pushes hand-computed {last,data}
// per output when a beat is accepted; a negedge monitor pops on each output handshake.
module tb_cory_dmx2_burst;

    logic       clk;
    logic       reset_n;
    logic       i_a_v;
    logic [7:0] i_a_d;
    logic       i_a_s;
    logic [3:0] i_a_len;
    logic       o_a_r;
    logic       o_z0_v;
    logic [7:0] o_z0_d;
    logic       o_z0_last;
    logic       i_z0_r;
    logic       o_z1_v;
    logic [7:0] o_z1_d;
    logic       o_z1_last;
    logic       i_z1_r;
    logic       o_busy;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [8:0]  exp0[$];
    logic [8:0]  exp1[$];

    cory_dmx2_burst #(.N(8), .L(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_a_v     (i_a_v),
        .i_a_d     (i_a_d),
        .i_a_s     (i_a_s),
        .i_a_len   (i_a_len),
        .o_a_r     (o_a_r),
        .o_z0_v    (o_z0_v),
        .o_z0_d    (o_z0_d),
        .o_z0_last (o_z0_last),
        .i_z0_r    (i_z0_r),
        .o_z1_v    (o_z1_v),
        .o_z1_d    (o_z1_d),
        .o_z1_last (o_z1_last),
        .i_z1_r    (i_z1_r),
        .o_busy    (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one beat and holds it until accepted; pushes the expected output entry.
    task automatic send(input logic s, input logic [3:0] len, input logic [7:0] d,
                        input logic dest, input logic last, output int unsigned stalls);
        bit ok = 1'b0;
        stalls  = 0;
        i_a_v   = 1'b1;
        i_a_s   = s;
        i_a_len = len;
        i_a_d   = d;
        while (!ok && stalls < 50) begin
            @(negedge clk);
            if (o_a_r === 1'b1) ok = 1'b1;
            else stalls++;
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: beat %0h not accepted within 50 cycles", d);
        end else if (dest) begin
            exp1.push_back({last, d});
        end else begin
            exp0.push_back({last, d});
        end
        @(posedge clk);
        #1;
        i_a_v   = 1'b0;
        i_a_s   = 1'bx;
        i_a_len = 4'bxxxx;
        i_a_d   = 8'hxx;
    endtask

    task automatic wait_cycles(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: compares every completed output handshake against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (o_z0_v && i_z0_r) begin
                    if (exp0.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL z0_unexpected: got %0h, expected no beat", {o_z0_last, o_z0_d});
                    end else begin
                        check("z0_beat", {23'd0, o_z0_last, o_z0_d}, {23'd0, exp0.pop_front()});
                    end
                end
                if (o_z1_v && i_z1_r) begin
                    if (exp1.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL z1_unexpected: got %0h, expected no beat", {o_z1_last, o_z1_d});
                    end else begin
                        check("z1_beat", {23'd0, o_z1_last, o_z1_d}, {23'd0, exp1.pop_front()});
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned st;
        reset_n = 1'b0;
        i_a_v   = 1'b0;
        i_a_d   = 8'h00;
        i_a_s   = 1'b0;
        i_a_len = 4'h0;
        i_z0_r  = 1'b1;
        i_z1_r  = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_z0_v", o_z0_v, 0);
        check("rst_z1_v", o_z1_v, 0);
        check("rst_z0_last", o_z0_last, 0);
        check("rst_z1_last", o_z1_last, 0);
        check("rst_busy", o_busy, 0);
        check("rst_a_r", o_a_r, 1);
        @(posedge clk);
        #1 reset_n = 1'b1;
        wait_cycles(1);

        // 1: single beat to z1
        send(1'b1, 4'h0, 8'hA5, 1'b1, 1'b1, st);
        check("t1_stalls", st, 0);
        @(negedge clk);
        check("t1_z1_v", o_z1_v, 1);
        check("t1_z0_v", o_z0_v, 0);
        wait_cycles(1);

        // 2: 4-beat burst to z0, i_a_s toggled on data beats
        send(1'b0, 4'h3, 8'h10, 1'b0, 1'b0, st);
        check("t2_busy_b1", o_busy, 1);
        send(1'b1, 4'h0, 8'h11, 1'b0, 1'b0, st);
        check("t2_busy_b2", o_busy, 1);
        send(1'b1, 4'h7, 8'h12, 1'b0, 1'b0, st);
        check("t2_busy_b3", o_busy, 1);
        send(1'b1, 4'h0, 8'h13, 1'b0, 1'b1, st);
        check("t2_busy_b4", o_busy, 0);
        wait_cycles(3);

        // 3: z0 stalled and full; other output still flows
        i_z0_r = 1'b0;
        send(1'b0, 4'h1, 8'h20, 1'b0, 1'b0, st);
        send(1'b0, 4'h0, 8'h21, 1'b0, 1'b1, st);
        send(1'b1, 4'h0, 8'h30, 1'b1, 1'b1, st);
        check("t3_other_stalls", st, 0);
        repeat (3) begin
            @(negedge clk);
            check("t3_z0_v_hold", o_z0_v, 1);
            check("t3_z0_d_hold", o_z0_d, 8'h20);
            check("t3_z0_last_hold", o_z0_last, 0);
        end
        @(posedge clk);
        #1 i_z0_r = 1'b1;
        wait_cycles(4);
        check("t3_drained", exp0.size() + exp1.size(), 0);

        // 4: third beat into a full z0 waits for one pop
        i_z0_r = 1'b0;
        send(1'b0, 4'h0, 8'h40, 1'b0, 1'b1, st);
        send(1'b0, 4'h0, 8'h41, 1'b0, 1'b1, st);
        fork
            begin
                send(1'b0, 4'h0, 8'h42, 1'b0, 1'b1, st);
            end
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("t4_a_r_low", o_a_r, 0);
                end
                @(posedge clk);
                #1 i_z0_r = 1'b1;
            end
        join
        check("t4_stalls", st, 4);
        wait_cycles(4);
        check("t4_drained", exp0.size(), 0);

        // 5: maximum-length burst to z1
        for (int i = 0; i < 16; i++) begin
            send(1'b1, 4'hF, 8'h50 + 8'(i), 1'b1, (i == 15), st);
        end
        check("t5_busy_end", o_busy, 0);
        wait_cycles(3);
        check("t5_drained", exp1.size(), 0);

        // 6: reset in the middle of a burst
        i_z0_r = 1'b0;
        send(1'b0, 4'h5, 8'h60, 1'b0, 1'b0, st);
        send(1'b0, 4'h5, 8'h61, 1'b0, 1'b0, st);
        check("t6_busy_mid", o_busy, 1);
        check("t6_z0_v_mid", o_z0_v, 1);
        reset_n = 1'b0;
        #1;
        check("t6_rst_z0_v", o_z0_v, 0);
        check("t6_rst_z1_v", o_z1_v, 0);
        check("t6_rst_busy", o_busy, 0);
        exp0.delete();
        exp1.delete();
        @(posedge clk);
        #1 reset_n = 1'b1;
        i_z0_r = 1'b1;
        check("t6_a_r", o_a_r, 1);
        check("t6_busy_after", o_busy, 0);
        send(1'b1, 4'h0, 8'h70, 1'b1, 1'b1, st);
        check("t6_hdr_busy", o_busy, 0);
        wait_cycles(4);
        check("final_empty", exp0.size() + exp1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
